reorder_buffer: RTL

In-order retirement buffer that feeds the register file's write-back port. It accepts one dispatched instruction per cycle with its architectural and renamed destination numbers. It captures execution results from both common data buses by renamed register number. It retires completed, non-speculative entries in program order by driving a commit write (data, arn, rrn) that frees the renamed register. It also honours the global speculation controls `delete_tagged` and `clear_tags`.

---
 rtl/rob_pkg.sv | 21 ++
 rtl/rob_result_match.sv | 36 +++
 rtl/reorder_buffer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/rob_pkg.sv
// Shared types and constants for the reorder buffer.
package rob_pkg;
   localparam int unsigned ROB_XLEN = 32;
   localparam int unsigned REG_W    = 6;
   localparam logic [REG_W-1:0] REN_BASE = 6'd32;
   localparam logic [REG_W-1:0] REN_LAST = 6'd63;

   typedef struct packed {
      logic                valid;
      logic                done;
      logic                tag;
      logic [REG_W-1:0]    arn;
      logic [REG_W-1:0]    rrn;
      logic [ROB_XLEN-1:0] data;
   } rob_entry_t;

   // True when a register number lies in the renamed range.
   function automatic logic is_ren(input logic [REG_W-1:0] r);
      return ({1'b0, r} >= {1'b0, REN_BASE}) && ({1'b0, r} <= {1'b0, REN_LAST});
   endfunction
endpackage

// File: rtl/rob_result_match.sv
// Per-entry renamed-register match against both result buses; bus 1 wins a tie.
module rob_result_match
   import rob_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned XLEN  = 32
) (
   input  logic [DEPTH-1:0]            pend,
   input  logic [DEPTH-1:0][REG_W-1:0] ent_rrn,
   input  logic [1:0]                  res_we,
   input  logic [1:0][REG_W-1:0]       res_rrn,
   input  logic [1:0][XLEN-1:0]        res_data,
   output logic [DEPTH-1:0]            hit,
   output logic [DEPTH-1:0][XLEN-1:0]  hit_data
);
   logic [1:0]       bus_ok;
   logic [DEPTH-1:0] hit0;
   logic [DEPTH-1:0] hit1;

   always_comb begin
      bus_ok   = '0;
      hit0     = '0;
      hit1     = '0;
      hit      = '0;
      hit_data = '0;
      for (int k = 0; k < 2; k++) begin
         bus_ok[k] = res_we[k] && is_ren(res_rrn[k]);
      end
      for (int i = 0; i < int'(DEPTH); i++) begin
         hit0[i]     = bus_ok[0] && pend[i] && (ent_rrn[i] == res_rrn[0]);
         hit1[i]     = bus_ok[1] && pend[i] && (ent_rrn[i] == res_rrn[1]);
         hit[i]      = hit0[i] || hit1[i];
         hit_data[i] = hit1[i] ? res_data[1] : res_data[0];
      end
   end
endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: dispatch at tail, CDB result capture, commit at head,
// with speculative squash (delete_tagged) and resolve (clear_tags).
module reorder_buffer
   import rob_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned XLEN  = 32
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    disp_valid,
   output logic                    disp_ready,
   input  logic [5:0]              disp_arn,
   input  logic [5:0]              disp_rrn,
   input  logic                    disp_tag,
   input  logic [1:0]              res_we,
   input  logic [1:0][5:0]         res_rrn,
   input  logic [1:0][XLEN-1:0]    res_data,
   input  logic                    delete_tagged,
   input  logic                    clear_tags,
   output logic                    commit_we,
   output logic [5:0]              commit_arn,
   output logic [5:0]              commit_rrn,
   output logic [XLEN-1:0]         commit_data,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    full,
   output logic                    empty
);
   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned PTR_W = IDX_W + 1;

   rob_entry_t entries_q [DEPTH];
   rob_entry_t entries_n [DEPTH];
   rob_entry_t head_e;

   logic [PTR_W-1:0] head_q, head_n, tail_q, tail_n, count_n, n_tagged;
   logic [IDX_W-1:0] head_idx, tail_idx;
   logic             commit_c, commit_fire_c, accept_c;

   logic [DEPTH-1:0]            pend;
   logic [DEPTH-1:0][REG_W-1:0] ent_rrn;
   logic [DEPTH-1:0]            hit;
   logic [DEPTH-1:0][XLEN-1:0]  hit_data;

   assign disp_ready = !full;
   assign head_idx   = head_q[IDX_W-1:0];
   assign tail_idx   = tail_q[IDX_W-1:0];

   // Only entries still waiting on a result may be written by a CDB.
   always_comb begin
      pend    = '0;
      ent_rrn = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         pend[i]    = entries_q[i].valid && !entries_q[i].done;
         ent_rrn[i] = entries_q[i].rrn;
      end
   end

   rob_result_match #(.DEPTH(DEPTH), .XLEN(XLEN)) u_match (
      .pend     (pend),
      .ent_rrn  (ent_rrn),
      .res_we   (res_we),
      .res_rrn  (res_rrn),
      .res_data (res_data),
      .hit      (hit),
      .hit_data (hit_data)
   );

   // Next-state for entries and pointers.
   always_comb begin
      entries_n     = entries_q;
      head_n        = head_q;
      tail_n        = tail_q;
      n_tagged      = '0;
      head_e        = entries_q[head_idx];
      commit_c      = head_e.valid && head_e.done && !head_e.tag;
      commit_fire_c = commit_c && (head_e.arn != '0);
      accept_c      = disp_valid && !full && !delete_tagged;

      for (int i = 0; i < int'(DEPTH); i++) begin
         if (entries_q[i].valid && entries_q[i].tag) begin
            n_tagged = n_tagged + PTR_W'(1);
         end
         if (hit[i]) begin
            entries_n[i].done = 1'b1;
            entries_n[i].data = ROB_XLEN'(hit_data[i]);
         end
         if (clear_tags) begin
            entries_n[i].tag = 1'b0;
         end
      end

      if (commit_c) begin
         entries_n[head_idx].valid = 1'b0;
         head_n = head_q + PTR_W'(1);
      end

      // Tagged entries are contiguous at the tail, so the tail rewinds by their count.
      if (delete_tagged) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            if (entries_q[i].valid && entries_q[i].tag) begin
               entries_n[i].valid = 1'b0;
            end
         end
         tail_n = tail_q - n_tagged;
      end else if (accept_c) begin
         entries_n[tail_idx].valid = 1'b1;
         entries_n[tail_idx].done  = 1'b0;
         entries_n[tail_idx].tag   = disp_tag;
         entries_n[tail_idx].arn   = disp_arn;
         entries_n[tail_idx].rrn   = disp_rrn;
         entries_n[tail_idx].data  = '0;
         tail_n = tail_q + PTR_W'(1);
      end

      count_n = tail_n - head_n;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            entries_q[i] <= '0;
         end
         head_q      <= '0;
         tail_q      <= '0;
         commit_we   <= 1'b0;
         commit_arn  <= '0;
         commit_rrn  <= '0;
         commit_data <= '0;
         count       <= '0;
         full        <= 1'b0;
         empty       <= 1'b1;
      end else begin
         entries_q <= entries_n;
         head_q    <= head_n;
         tail_q    <= tail_n;
         commit_we <= commit_fire_c;
         if (commit_fire_c) begin
            commit_arn  <= head_e.arn;
            commit_rrn  <= head_e.rrn;
            commit_data <= XLEN'(head_e.data);
         end
         count <= count_n;
         full  <= (count_n == PTR_W'(DEPTH));
         empty <= (count_n == '0);
      end
   end
endmodule
